// File: rtl/line_mem_ctrl_pkg.sv
// Shared types and constants for the line memory controller.
// Optional statistics counters are enabled by LINE_MEM_STATS_EN.
package line_mem_ctrl_pkg;

  localparam int LINE_W   = 128;
  localparam int OFFSET_W = 4;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/line_mem_ctrl_if.sv
// Cache <-> memory line request / completion bundle.
// master = cache side, slave = memory controller side.
interface line_mem_ctrl_if
  import line_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic              cache2mem_rw;
  logic              cache2mem_valid;
  logic [ADDR_W-1:0] cache2mem_addr;
  logic [LINE_W-1:0] cache2mem_data;
  logic              mem2cache_ready;
  logic [LINE_W-1:0] mem2cache_data;

  modport master (
    output cache2mem_rw,
    output cache2mem_valid,
    output cache2mem_addr,
    output cache2mem_data,
    input  mem2cache_ready,
    input  mem2cache_data
  );

  modport slave (
    input  cache2mem_rw,
    input  cache2mem_valid,
    input  cache2mem_addr,
    input  cache2mem_data,
    output mem2cache_ready,
    output mem2cache_data
  );

endinterface

// File: rtl/line_mem_array.sv
// Line backing store: synchronous write, combinational read.
// Not reset; contents survive a controller reset.
module line_mem_array
  import line_mem_ctrl_pkg::*;
#(
  parameter int DEPTH_LINES = 1024,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH_LINES];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/line_mem_ctrl.sv
// Fixed-latency line memory controller with a one-entry pending slot.
// LINE_MEM_STATS_EN adds read/write completion counters.
module line_mem_ctrl
  import line_mem_ctrl_pkg::*;
#(
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4,
  parameter int ADDR_W      = 32
) (
  input  logic clk,
  input  logic r,
  line_mem_ctrl_if.slave bus,
  output logic mem_overflow
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0] mem_rd_count,
  output logic [31:0] mem_wr_count
`endif
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              act_rw, act_rw_n;
  logic [IDX_W-1:0]  act_idx, act_idx_n;
  logic [LINE_W-1:0] act_data, act_data_n;
  logic              pend_v, pend_v_n;
  logic              pend_rw, pend_rw_n;
  logic [IDX_W-1:0]  pend_idx, pend_idx_n;
  logic [LINE_W-1:0] pend_data, pend_data_n;
  logic              ovf_n;
  logic [IDX_W-1:0]  req_idx;
  logic [LINE_W-1:0] rd_line;
  logic              resp;
  logic              unused_addr;

  assign req_idx     = bus.cache2mem_addr[OFFSET_W+IDX_W-1:OFFSET_W];
  assign unused_addr = ^bus.cache2mem_addr;
  assign resp        = (state == ST_RESP);

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      act_rw    <= 1'b0;
      act_idx   <= '0;
      act_data  <= '0;
      pend_v    <= 1'b0;
      pend_rw   <= 1'b0;
      pend_idx  <= '0;
      pend_data <= '0;
      mem_overflow <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      act_rw    <= act_rw_n;
      act_idx   <= act_idx_n;
      act_data  <= act_data_n;
      pend_v    <= pend_v_n;
      pend_rw   <= pend_rw_n;
      pend_idx  <= pend_idx_n;
      pend_data <= pend_data_n;
      mem_overflow <= ovf_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    act_rw_n    = act_rw;
    act_idx_n   = act_idx;
    act_data_n  = act_data;
    pend_v_n    = pend_v;
    pend_rw_n   = pend_rw;
    pend_idx_n  = pend_idx;
    pend_data_n = pend_data;
    ovf_n       = mem_overflow;
    unique case (state)
      ST_IDLE: begin
        if (bus.cache2mem_valid) begin
          act_rw_n   = bus.cache2mem_rw;
          act_idx_n  = req_idx;
          act_data_n = bus.cache2mem_data;
          cnt_n      = CNT_LOAD;
          state_n    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt == '0) state_n = ST_RESP;
        else cnt_n = cnt - 1'b1;
        if (bus.cache2mem_valid) begin
          if (pend_v) begin
            ovf_n = 1'b1;
          end else begin
            pend_v_n    = 1'b1;
            pend_rw_n   = bus.cache2mem_rw;
            pend_idx_n  = req_idx;
            pend_data_n = bus.cache2mem_data;
          end
        end
      end
      ST_RESP: begin
        // Promoting the pending entry frees the slot for a same-cycle request
        if (pend_v) begin
          act_rw_n    = pend_rw;
          act_idx_n   = pend_idx;
          act_data_n  = pend_data;
          cnt_n       = CNT_LOAD;
          state_n     = ST_BUSY;
          pend_v_n    = bus.cache2mem_valid;
          pend_rw_n   = bus.cache2mem_rw;
          pend_idx_n  = req_idx;
          pend_data_n = bus.cache2mem_data;
        end else if (bus.cache2mem_valid) begin
          act_rw_n   = bus.cache2mem_rw;
          act_idx_n  = req_idx;
          act_data_n = bus.cache2mem_data;
          cnt_n      = CNT_LOAD;
          state_n    = ST_BUSY;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  line_mem_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (resp && act_rw),
    .idx   (act_idx),
    .wdata (act_data),
    .rdata (rd_line)
  );

  assign bus.mem2cache_ready = resp;
  assign bus.mem2cache_data  = (resp && !act_rw) ? rd_line : '0;

`ifdef LINE_MEM_STATS_EN
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      mem_rd_count <= '0;
      mem_wr_count <= '0;
    end else if (resp) begin
      if (act_rw) mem_wr_count <= mem_wr_count + 32'd1;
      else mem_rd_count <= mem_rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Scoreboard bench for line_mem_ctrl: directed scenarios plus random traffic.
// Exercises LINE_MEM_STATS_EN counters when the macro is defined.
module tb_line_mem_ctrl;

  localparam int DEPTH = 1024;
  localparam int LAT   = 4;

  typedef struct {
    logic [127:0] data;
    bit           rd;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ovf;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_rd = 0;
  int   n_wr = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [127:0] model [DEPTH];

`ifdef LINE_MEM_STATS_EN
  logic [31:0] rd_cnt, wr_cnt;
`endif

  line_mem_ctrl_if #(.ADDR_W(32)) bus();

  line_mem_ctrl #(
    .DEPTH_LINES (DEPTH),
    .LATENCY     (LAT),
    .ADDR_W      (32)
  ) dut (
    .clk          (clk),
    .r            (rst_n),
    .bus          (bus),
    .mem_overflow (ovf)
`ifdef LINE_MEM_STATS_EN
    ,
    .mem_rd_count (rd_cnt),
    .mem_wr_count (wr_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got,
                     input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem2cache_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 128'd1, 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk(e.rd ? "read_data" : "write_data", bus.mem2cache_data, e.data);
          if (e.due >= 0) chk("latency", 128'(cyc), 128'(e.due));
          if (e.rd) n_rd++;
          else n_wr++;
        end
      end else begin
        chk("idle_data_zero", bus.mem2cache_data, 128'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit rw, input logic [31:0] addr,
                       input logic [127:0] d, input bit no_effect);
    exp_t x;
    int idx;
    if (!no_effect) begin
      idx = int'((addr >> 4) % DEPTH);
      x.rd = !rw;
      if (rw) begin
        model[idx] = d;
        x.data = '0;
      end else begin
        x.data = model[idx];
      end
      x.due = (exp_q.size() == 0) ? cyc + 1 + LAT : -1;
      exp_q.push_back(x);
    end
    bus.cache2mem_valid = 1'b1;
    bus.cache2mem_rw    = rw;
    bus.cache2mem_addr  = addr;
    bus.cache2mem_data  = d;
    step();
    bus.cache2mem_valid = 1'b0;
    bus.cache2mem_data  = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
    end
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_ready", 128'(bus.mem2cache_ready), 128'd0);
    chk("reset_data", bus.mem2cache_data, 128'd0);
    chk("reset_ovf", 128'(ovf), 128'd0);
    step();
    step();
    rst_n = 1'b1;
    n_rd = 0;
    n_wr = 0;
    step();
  endtask

  logic [127:0] d;
  logic [31:0]  a;

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    bus.cache2mem_valid = 1'b0;
    bus.cache2mem_rw    = 1'b0;
    bus.cache2mem_addr  = '0;
    bus.cache2mem_data  = '0;
    step();
    do_reset();

    // Read of untouched memory after reset
    issue(1'b0, 32'h0000_1234, '0, 1'b0);
    drain();

    // Write then read, counters observed from a clean reset
    do_reset();
    issue(1'b1, 32'h0000_5678, {4{32'hFEEDFACE}}, 1'b0);
    drain();
    issue(1'b0, 32'h0000_5678, '0, 1'b0);
    drain();
`ifdef LINE_MEM_STATS_EN
    chk("rd_count", 128'(rd_cnt), 128'd1);
    chk("wr_count", 128'(wr_cnt), 128'd1);
`endif

    // Back-to-back write/read to one line
    issue(1'b1, 32'h0000_1230, {4{32'hDEADBEEF}}, 1'b0);
    issue(1'b0, 32'h0000_1230, '0, 1'b0);
    drain();
    chk("b2b_ovf", 128'(ovf), 128'd0);

    // Three consecutive requests: third is dropped
    issue(1'b1, 32'h0000_3000, {4{32'h1234_5678}}, 1'b0);
    issue(1'b0, 32'h0000_3000, '0, 1'b0);
    issue(1'b1, 32'h0000_3000, {4{32'hBAD0_BAD0}}, 1'b1);
    drain();
    chk("ovf_set", 128'(ovf), 128'd1);
    repeat (5) step();
    chk("ovf_sticky", 128'(ovf), 128'd1);
    issue(1'b0, 32'h0000_3000, '0, 1'b0);
    drain();
    do_reset();

    // Aliasing across upper address bits
    issue(1'b1, 32'h0000_0010, {4{32'hA11A_5EED}}, 1'b0);
    drain();
    issue(1'b0, 32'h0000_4010, '0, 1'b0);
    drain();

    // Reset while a write is in flight: write never commits
    issue(1'b1, 32'h0000_0020, {4{32'h0DD0_0DD0}}, 1'b0);
    drain();
    issue(1'b1, 32'h0000_0020, {4{32'h5555_AAAA}}, 1'b1);
    step();
    do_reset();
    repeat (LAT + 2) step();
    issue(1'b0, 32'h0000_0020, '0, 1'b0);
    drain();

    // Random traffic, never more than two outstanding
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() < 2 && $urandom_range(0, 2) != 0) begin
        a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 7)) << 4)
            | ($urandom & 32'hF);
        d = {$urandom, $urandom, $urandom, $urandom};
        issue(1'($urandom_range(0, 1)), a, d, 1'b0);
      end else begin
        step();
      end
    end
    drain();
    chk("random_ovf", 128'(ovf), 128'd0);
`ifdef LINE_MEM_STATS_EN
    chk("rnd_rd_count", 128'(rd_cnt), 128'(n_rd));
    chk("rnd_wr_count", 128'(wr_cnt), 128'(n_wr));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
